calc1: RTL and testbench

CALC1 -- requirements
Module: calc1

---
 rtl/calc1.sv | 147 ++++++++++++++
 tb/tb_calc1.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/calc1.sv
// Four-lane request/response calculator: each lane takes a two-cycle operand frame and answers one cycle later.
// Optional shift commands are compiled in with `define CALC1_SHIFT_EN.

package calc1_pkg;
  localparam int NUM_LANES = 4;
  localparam int DATA_W    = 32;
  localparam int CMD_W     = 4;
  localparam int STAGES    = 2;

  localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RSP_NONE = 2'd0;
  localparam logic [1:0] RSP_OK   = 2'd1;
  localparam logic [1:0] RSP_ERR  = 2'd2;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef struct packed {
    logic [1:0]        resp;
    logic [DATA_W-1:0] data;
  } rsp_t;
endpackage

module calc1_lane
  import calc1_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  req_t req_i,
  output rsp_t rsp_o
);
  // vld_pipe_q[1]: waiting for operand 2; vld_pipe_q[2]: operands complete, result lands next edge
  logic [STAGES:0]   vld_pipe_d, vld_pipe_q;
  logic [CMD_W-1:0]  cmd_d, cmd_q;
  logic [DATA_W-1:0] op1_d, op1_q;
  logic [DATA_W-1:0] op2_d, op2_q;
  rsp_t              rsp_d, rsp_q;
  logic [DATA_W:0]   sum;
  logic              accept;

  always_comb begin
    // a new frame may start on the same edge the previous result is registered
    accept        = (req_i.cmd != CMD_NOP) && !vld_pipe_q[1];
    vld_pipe_d    = {vld_pipe_q[STAGES-1:1], accept, 1'b0};
    vld_pipe_d[0] = accept;
    cmd_d         = accept ? req_i.cmd : cmd_q;
    op1_d         = accept ? req_i.data : op1_q;
    op2_d         = vld_pipe_q[1] ? req_i.data : op2_q;
    sum           = {1'b0, op1_q} + {1'b0, op2_q};

    rsp_d = '0;
    if (vld_pipe_q[STAGES]) begin
      case (cmd_q)
        CMD_ADD: begin
          if (sum[DATA_W]) rsp_d.resp = RSP_ERR;
          else             rsp_d = '{resp: RSP_OK, data: sum[DATA_W-1:0]};
        end
        CMD_SUB: begin
          if (op2_q > op1_q) rsp_d.resp = RSP_ERR;
          else               rsp_d = '{resp: RSP_OK, data: op1_q - op2_q};
        end
`ifdef CALC1_SHIFT_EN
        CMD_SHL: rsp_d = '{resp: RSP_OK, data: op1_q << op2_q[4:0]};
        CMD_SHR: rsp_d = '{resp: RSP_OK, data: op1_q >> op2_q[4:0]};
`endif
        default: rsp_d.resp = RSP_ERR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      cmd_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      rsp_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      cmd_q      <= cmd_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      rsp_q      <= rsp_d;
    end
  end

  assign rsp_o = rsp_q;
endmodule

module calc1
  import calc1_pkg::*;
(
  output logic [0:31] out_data1,
  output logic [0:31] out_data2,
  output logic [0:31] out_data3,
  output logic [0:31] out_data4,
  output logic [0:1]  out_resp1,
  output logic [0:1]  out_resp2,
  output logic [0:1]  out_resp3,
  output logic [0:1]  out_resp4,
  input  logic        c_clk,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req4_data_in,
  input  logic [1:7]  reset
);
  logic                  rst;
  req_t [NUM_LANES-1:0]  req;
  rsp_t [NUM_LANES-1:0]  rsp;

  // port vectors are MSB-first ([0:N]); plain assignment keeps bit 0 as the MSB
  assign rst    = |reset;
  assign req[0] = {req1_cmd_in, req1_data_in};
  assign req[1] = {req2_cmd_in, req2_data_in};
  assign req[2] = {req3_cmd_in, req3_data_in};
  assign req[3] = {req4_cmd_in, req4_data_in};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    calc1_lane u_lane (
      .clk   (c_clk),
      .rst   (rst),
      .req_i (req[i]),
      .rsp_o (rsp[i])
    );
  end

  assign out_data1 = rsp[0].data;
  assign out_data2 = rsp[1].data;
  assign out_data3 = rsp[2].data;
  assign out_data4 = rsp[3].data;
  assign out_resp1 = rsp[0].resp;
  assign out_resp2 = rsp[1].resp;
  assign out_resp3 = rsp[2].resp;
  assign out_resp4 = rsp[3].resp;
endmodule

// File: tb/tb_calc1.sv
// Directed bench for calc1: hand-computed vectors per lane, back-to-back frames, concurrency and reset.
module tb_calc1;
  logic        c_clk = 1'b0;
  logic [1:7]  reset;
  logic [3:0]  cmd [4];
  logic [31:0] dat [4];
  logic [0:31] od1, od2, od3, od4;
  logic [0:1]  or1, or2, or3, or4;
  logic [31:0] odat [4];
  logic [1:0]  ores [4];
  int n_chk = 0;
  int n_err = 0;

  always #5 c_clk = ~c_clk;

  calc1 dut (
    .out_data1(od1), .out_data2(od2), .out_data3(od3), .out_data4(od4),
    .out_resp1(or1), .out_resp2(or2), .out_resp3(or3), .out_resp4(or4),
    .c_clk(c_clk),
    .req1_cmd_in(cmd[0]), .req1_data_in(dat[0]),
    .req2_cmd_in(cmd[1]), .req2_data_in(dat[1]),
    .req3_cmd_in(cmd[2]), .req3_data_in(dat[2]),
    .req4_cmd_in(cmd[3]), .req4_data_in(dat[3]),
    .reset(reset)
  );

  assign odat[0] = od1; assign odat[1] = od2; assign odat[2] = od3; assign odat[3] = od4;
  assign ores[0] = or1; assign ores[1] = or2; assign ores[2] = or3; assign ores[3] = or4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("%s resp%0d", tag, p + 1), 32'(ores[p]), 32'd0);
      chk($sformatf("%s data%0d", tag, p + 1), odat[p], 32'd0);
    end
  endtask

  // one complete frame on port p; checks the one-cycle result and its return to zero
  task automatic frame(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] er, input logic [31:0] ed, input string tag);
    @(negedge c_clk); cmd[p] = c;     dat[p] = a;
    @(negedge c_clk); cmd[p] = 4'hF;  dat[p] = b;
    @(negedge c_clk); cmd[p] = 4'h0;  dat[p] = '0;
    @(posedge c_clk); #1;
    chk({tag, " resp"}, 32'(ores[p]), 32'(er));
    chk({tag, " data"}, odat[p], ed);
    @(posedge c_clk); #1;
    chk({tag, " clr resp"}, 32'(ores[p]), 32'd0);
    chk({tag, " clr data"}, odat[p], 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] x;
    reset = '1;
    for (int p = 0; p < 4; p++) begin cmd[p] = '0; dat[p] = '0; end
    repeat (2) @(posedge c_clk);
    // commands during reset are ignored
    @(negedge c_clk); cmd[0] = 4'd1; dat[0] = 32'd9;
    @(posedge c_clk); #1;
    chk_idle("rst");
    @(negedge c_clk); cmd[0] = 4'd1; dat[0] = 32'd11;
    @(negedge c_clk); cmd[0] = 4'd0; dat[0] = '0;
    repeat (2) @(posedge c_clk); #1;
    chk("rst ignored resp", 32'(ores[0]), 32'd0);

    // first frame accepted on the first edge with reset low
    @(negedge c_clk); reset = '0; cmd[0] = 4'd1; dat[0] = 32'd100;
    @(negedge c_clk); cmd[0] = 4'd0; dat[0] = 32'd23;
    @(negedge c_clk); dat[0] = '0;
    @(posedge c_clk); #1;
    chk("first resp", 32'(ores[0]), 32'd1);
    chk("first data", odat[0], 32'd123);
    @(posedge c_clk); #1;
    chk_idle("idle");

    frame(0, 4'd1, 32'h00000001, 32'h1FFFFFFF, 2'd1, 32'h20000000, "add carry-in");
    frame(0, 4'd1, 32'h1FFFFFFF, 32'h1FFFFFFF, 2'd1, 32'h3FFFFFFE, "add big");
    frame(0, 4'd1, 32'h0,        32'h0,        2'd1, 32'h0,        "add zero");
    frame(0, 4'd1, 32'hFFFFFFFF, 32'h00000001, 2'd2, 32'h0,        "add ovf");
    frame(0, 4'd2, 32'h1,        32'hF,        2'd2, 32'h0,        "sub unf");
    frame(0, 4'd2, 32'hF,        32'h1,        2'd1, 32'hE,        "sub ok");
    frame(0, 4'd2, 32'h7,        32'h7,        2'd1, 32'h0,        "sub equal");
    frame(0, 4'd3, 32'h1,        32'h1,        2'd2, 32'h0,        "cmd3");
    frame(0, 4'd4, 32'h1,        32'h1,        2'd2, 32'h0,        "cmd4");
    frame(0, 4'd15, 32'h1,       32'h1,        2'd2, 32'h0,        "cmd15");
`ifdef CALC1_SHIFT_EN
    frame(0, 4'd5, 32'h1,        32'd4,        2'd1, 32'h10,       "shl");
    frame(0, 4'd6, 32'h80000000, 32'd31,       2'd1, 32'h1,        "shr");
    frame(0, 4'd5, 32'hFFFFFFFF, 32'h20,       2'd1, 32'hFFFFFFFF, "shl amt wraps");
`else
    frame(0, 4'd5, 32'h1,        32'd4,        2'd2, 32'h0,        "shl off");
    frame(0, 4'd6, 32'h80000000, 32'd31,       2'd2, 32'h0,        "shr off");
`endif
    x = 32'd1;
    for (int i = 0; i < 15; i++) begin
      frame(0, 4'd1, x, 32'h0, 2'd1, x, $sformatf("sweep %0h", x));
      x = x << 1;
    end
    frame(3, 4'd2, 32'h10, 32'h3, 2'd1, 32'hD, "port4 sub");

    // back-to-back: B starts on A's result edge
    @(negedge c_clk); cmd[0] = 4'd1; dat[0] = 32'd2;
    @(negedge c_clk); cmd[0] = 4'd0; dat[0] = 32'd3;
    @(negedge c_clk); cmd[0] = 4'd2; dat[0] = 32'd9;
    @(posedge c_clk); #1;
    chk("b2b A resp", 32'(ores[0]), 32'd1);
    chk("b2b A data", odat[0], 32'd5);
    @(negedge c_clk); cmd[0] = 4'd0; dat[0] = 32'd1;
    @(posedge c_clk); #1;
    chk("b2b gap resp", 32'(ores[0]), 32'd0);
    @(negedge c_clk); dat[0] = '0;
    @(posedge c_clk); #1;
    chk("b2b B resp", 32'(ores[0]), 32'd1);
    chk("b2b B data", odat[0], 32'd8);

    // all lanes in the same cycle
    @(negedge c_clk);
    cmd[0] = 4'd1; dat[0] = 32'd5;
    cmd[1] = 4'd2; dat[1] = 32'd10;
    cmd[2] = 4'd7; dat[2] = 32'd1;
    cmd[3] = 4'd2; dat[3] = 32'd1;
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) cmd[p] = 4'd0;
    dat[0] = 32'd7; dat[1] = 32'd3; dat[2] = 32'd1; dat[3] = 32'd2;
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) dat[p] = '0;
    @(posedge c_clk); #1;
    chk("par1 resp", 32'(ores[0]), 32'd1); chk("par1 data", odat[0], 32'd12);
    chk("par2 resp", 32'(ores[1]), 32'd1); chk("par2 data", odat[1], 32'd7);
    chk("par3 resp", 32'(ores[2]), 32'd2); chk("par3 data", odat[2], 32'd0);
    chk("par4 resp", 32'(ores[3]), 32'd2); chk("par4 data", odat[3], 32'd0);

    // reset[1] at E1 discards the frame
    @(negedge c_clk); cmd[0] = 4'd1; dat[0] = 32'd5;
    @(negedge c_clk); cmd[0] = 4'd0; dat[0] = 32'd6; reset = 7'b1000000;
    @(posedge c_clk); #1;
    chk_idle("rstE1");
    @(negedge c_clk); reset = '0; dat[0] = '0;
    @(posedge c_clk); #1;
    chk_idle("rstE2");
    @(posedge c_clk); #1;
    chk("rstE3 resp", 32'(ores[0]), 32'd0);
    frame(0, 4'd1, 32'd3, 32'd4, 2'd1, 32'd7, "post rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
